// File: rtl/regfile_param_sb.sv
// 2-read/1-write register file with busy scoreboard and power-up clear sequencer.
// Optional REGFILE_BYPASS_EN: same-cycle write-through to both read ports.
module regfile_param_sb #(
  parameter  int DATA_W   = 34,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                ready_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic run;
  logic wr_en;
  logic set_en;

  assign run    = (state_q == S_RUN);
  assign wr_en  = run && we && (wa != '0);
  assign set_en = run && busy_set && (busy_addr != '0);
  assign ready  = ready_q;

  // Clear first, then set, so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)
      busy_d[wa] = 1'b0;
    if (set_en)
      busy_d[busy_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      clr_idx_q <= '0;
      busy_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          busy_q <= busy_d;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Storage has no reset; the sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT)
        regs_q[clr_idx_q] <= '0;
      else if (wr_en)
        regs_q[wa] <= wd;
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (run && ra1 != '0) begin
      rd1   = regs_q[ra1];
      busy1 = busy_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wa == ra1) begin
        rd1   = wd;
        busy1 = set_en && (busy_addr == ra1);
      end
`endif
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (run && ra2 != '0) begin
      rd2   = regs_q[ra2];
      busy2 = busy_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wa == ra2) begin
        rd2   = wd;
        busy2 = set_en && (busy_addr == ra2);
      end
`endif
    end
  end

endmodule
